uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter that consumes the memory-mapped UART registers exported by the core (io_uart_io_reg, io_uart_csr_reg). It buffers bytes in a small FIFO and serialises them onto a single TX line as 8N1 frames. Status outputs are fed back to the memory map for software polling.

Parameters:
CLKS_PER_BIT, 104, clock cycles per bit; legal values are 2 and above; 104 gives 115200 baud at 12 MHz.
FIFO_DEPTH, 4, number of byte entries; must be a power of 2 and at least 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
io_uart_io_reg  input  32  UART data register from core; bits [7:0] are the byte to send
io_uart_csr_reg  input  32  UART control register from core; bit0 = send request, bit1 = overflow clear
tx  output  1  serial line; idles high
tx_busy  output  1  high when a frame is in flight or the FIFO is non-empty
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
fifo_empty  output  1  FIFO holds 0 entries
overflow  output  1  sticky flag: a push was dropped
tx_done  output  1  one-cycle pulse at the end of each stop bit

Behaviour:
- Reset values: tx=1, tx_busy=0, fifo_full=0, fifo_empty=1, overflow=0, tx_done=0; FSM=IDLE; FIFO pointers and count=0; csr edge register=0.
- Push detection:
  - csr_q registers io_uart_csr_reg[0].
  - push = csr[0] & ~csr_q; it fires once per rising edge.
  - Holding bit0 high does not cause a re-push.
  - Data io_uart_io_reg[7:0] is written at the clock edge ending the push cycle.
- Push acceptance:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle (count unchanged).
  - Otherwise the byte is dropped and overflow is set to 1 on the next edge.
- Overflow clear:
  - While csr[1]=1, overflow is forced to 0.
  - If a drop and csr[1]=1 occur in the same cycle, clear wins.
- FSM states are IDLE, START, DATA, STOP. A bit-timer counts 0..CLKS_PER_BIT-1; a bit index counts 0..7.
  - IDLE: tx=1. If the FIFO is non-empty: pop into the shift register, reset the timer, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0] (LSB first). Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. In the last cycle, tx_done=1.
    - If the FIFO is non-empty in that cycle: pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Latency: if push occurs in cycle N with the FSM idle and the FIFO empty, the FIFO is non-empty at N+1, the pop happens at N+1, and tx=0 from cycle N+2.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames have no gap.
- tx_busy = (state != IDLE) | ~fifo_empty.
- FIFO behaviour:
  - Pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
  - Count is clog2(FIFO_DEPTH)+1 bits.
  - fifo_full and fifo_empty are derived from the registered count.
- A pop is never issued on an empty FIFO.
- Reset mid-frame: tx returns to 1 on the next edge, the FIFO is flushed, and the partial frame is abandoned.
- io_uart_io_reg[31:8] and io_uart_csr_reg[31:2] are ignored.

Decomposition:
- Package uart_pkg contains:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t
  - localparam UART_CSR_SEND_BIT=0
  - localparam UART_CSR_OVF_CLR_BIT=1
  - localparam UART_DATA_BITS=8
- Sub-module uart_tx_fifo: synchronous byte FIFO.
  - Ports: clk, rst, push, din, pop, dout, full, empty.
  - dout is the head entry, read combinationally.
- uart_tx itself holds the edge detect, the FSM, the timers and the shift register.

Test Plan:
- Reset: assert rst for 3 cycles → tx=1, fifo_empty=1, tx_busy=0, overflow=0. Release with no push → tx stays 1 for 100 cycles.
- Single byte (CLKS_PER_BIT=4): data=0xA5, csr[0] 0→1 at cycle N and held high → tx=0 over N+2..N+5, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop bit=1. tx_done pulses at N+41. No second frame is sent.
- Back-to-back: push 0x55 then 0x0F two cycles apart → two contiguous 40-cycle frames with no idle cycle between them. tx_busy stays high throughout. tx_done pulses twice.
- Overflow (FIFO_DEPTH=4): with the first frame active, push 6 bytes 0x01..0x06 → 0x01 is popped and 0x02..0x05 are buffered. fifo_full=1. 0x06 is dropped and overflow=1. Serial output is 01,02,03,04,05.
- Overflow clear: with overflow=1, pulse csr[1] for 1 cycle → overflow=0 on the next edge. A new push succeeds. A drop coinciding with csr[1]=1 leaves overflow=0.
- Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued → tx=1 and fifo_empty=1 on the next edge. No frame is emitted after release until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int UART_CSR_SEND_BIT    = 0;
  localparam int UART_CSR_OVF_CLR_BIT = 1;
  localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO. The head entry is presented combinationally on dout.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] din,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW:0]               count;
  logic                      push_ok;
  logic                      pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  // Storage write; entries are not cleared by reset since count gates them.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed from the core's memory-mapped data/control
// registers. A rising edge on the send bit queues one byte; the FSM drains
// the queue back-to-back with no idle gap between frames.
// Handshake: a push is the single cycle where csr send bit is 1 and was 0
// the cycle before; the byte on io_uart_io_reg[7:0] is captured at the end
// of that cycle, and is dropped (setting overflow) if the FIFO is full and
// not popping in that same cycle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_uart_io_reg,
  input  logic [31:0] io_uart_csr_reg,
  output logic        tx,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow,
  output logic        tx_done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);

  uart_tx_state_t            state;
  uart_tx_state_t            state_next;
  logic [TW-1:0]             timer;
  logic [TW-1:0]             timer_next;
  logic [BW-1:0]             bit_idx;
  logic [BW-1:0]             bit_next;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] shift_next;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      csr_q;
  logic                      push;
  logic                      pop;
  logic                      drop;
  logic                      last_tick;
  logic                      unused;

  assign unused = ^{io_uart_io_reg[31:8], io_uart_csr_reg[31:2]};

  assign push      = io_uart_csr_reg[UART_CSR_SEND_BIT] & ~csr_q;
  assign drop      = push & fifo_full & ~pop;
  assign last_tick = (timer == TW'(CLKS_PER_BIT - 1));
  assign tx_busy   = (state != IDLE) | ~fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (io_uart_io_reg[UART_DATA_BITS-1:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, serial output and pop decode for the frame sequencer.
  always_comb begin
    state_next = state;
    timer_next = timer + TW'(1);
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    tx         = 1'b1;
    tx_done    = 1'b0;
    case (state)
      IDLE: begin
        timer_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (last_tick) begin
          timer_next = '0;
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        tx = shift[0];
        if (last_tick) begin
          timer_next = '0;
          shift_next = shift >> 1;
          if (bit_idx == BW'(UART_DATA_BITS - 1)) begin
            state_next = STOP;
          end else begin
            bit_next = bit_idx + BW'(1);
          end
        end
      end
      STOP: begin
        tx = 1'b1;
        if (last_tick) begin
          timer_next = '0;
          tx_done    = 1'b1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_dout;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        timer_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State, timers, shift register, send-edge history and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      csr_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      csr_q   <= io_uart_csr_reg[UART_CSR_SEND_BIT];
      if (io_uart_csr_reg[UART_CSR_OVF_CLR_BIT]) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A timing model predicts, from the pushes
// the bench drives, when each byte is popped and when its frame starts; a
// monitor decodes the serial line and checks status outputs every cycle.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_uart_io_reg  = '0;
  logic [31:0] io_uart_csr_reg = '0;
  logic        tx;
  logic        tx_busy;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic        tx_done;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .io_uart_io_reg  (io_uart_io_reg),
    .io_uart_csr_reg (io_uart_csr_reg),
    .tx              (tx),
    .tx_busy         (tx_busy),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .overflow        (overflow),
    .tx_done         (tx_done)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];     // bytes expected on the line, in order
  int         exp_t_q[$];   // cycle at which each frame's start bit begins
  int         m_push[$];    // push cycle of each accepted byte
  int         m_pop[$];     // pop cycle of each accepted byte
  int         last_pop = -1000;
  logic       ovf_m = 1'b0;
  logic       csr_prev = 1'b0;
  logic       started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A byte is held from the cycle after its push through its pop cycle.
  // It is popped one cycle after the push if the line is free, otherwise
  // exactly one frame after the previous pop. Its start bit follows its pop.
  always @(posedge clk) begin
    int n, occ;
    logic p, pop_now, drop;
    if (rst) begin
      m_push.delete(); m_pop.delete();
      exp_q.delete();  exp_t_q.delete();
      last_pop = -1000;
      ovf_m    = 1'b0;
      csr_prev = 1'b0;
      started  = 1'b1;
    end else begin
      n = cyc;
      p = io_uart_csr_reg[0] & ~csr_prev;
      csr_prev = io_uart_csr_reg[0];
      while (m_pop.size() > 0 && m_pop[0] + FRAME < n) begin
        void'(m_pop.pop_front());
        void'(m_push.pop_front());
      end
      occ = 0;
      pop_now = 1'b0;
      foreach (m_pop[i]) begin
        if (m_push[i] < n && m_pop[i] >= n) occ++;
        if (m_pop[i] == n) pop_now = 1'b1;
      end
      drop = 1'b0;
      if (p) begin
        if (occ < DEPTH || pop_now) begin
          int pt;
          pt = (n + 1 > last_pop + FRAME) ? n + 1 : last_pop + FRAME;
          last_pop = pt;
          m_push.push_back(n);
          m_pop.push_back(pt);
          exp_q.push_back(io_uart_io_reg[7:0]);
          exp_t_q.push_back(pt + 1);
        end else begin
          drop = 1'b1;
        end
      end
      if (io_uart_csr_reg[1]) ovf_m = 1'b0;
      else if (drop)          ovf_m = 1'b1;
    end
  end

  function automatic int occ_at(input int c);
    int k = 0;
    foreach (m_pop[i]) if (m_push[i] < c && m_pop[i] >= c) k++;
    return k;
  endfunction

  function automatic logic sending_at(input int c);
    foreach (m_pop[i]) if (c >= m_pop[i] + 1 && c <= m_pop[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic done_at(input int c);
    foreach (m_pop[i]) if (m_pop[i] + FRAME == c) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- monitor ----------------
  logic       in_frame = 1'b0;
  int         start_c  = 0;
  logic [7:0] mon_byte = '0;

  always @(posedge clk) begin
    int rel, occ;
    #1;
    if (started) begin
      occ = occ_at(cyc);
      check("fifo_empty", fifo_empty, occ == 0);
      check("fifo_full", fifo_full, occ == DEPTH);
      check("tx_busy", tx_busy, (occ > 0) || sending_at(cyc));
      check("tx_done", tx_done, done_at(cyc));
      check("overflow", overflow, ovf_m);
      if (rst) begin
        in_frame = 1'b0;
        check("tx_in_reset", tx, 1'b1);
      end else if (!in_frame) begin
        if (tx == 1'b0) begin
          if (exp_t_q.size() == 0) begin
            check("unexpected_start", 32'd1, 32'd0);
          end else begin
            check("start_cycle", cyc, exp_t_q[0]);
          end
          in_frame = 1'b1;
          start_c  = cyc;
        end else if (exp_t_q.size() > 0 && exp_t_q[0] == cyc) begin
          check("missing_start", 32'd1, 32'd0);
          void'(exp_q.pop_front());
          void'(exp_t_q.pop_front());
        end
      end else begin
        rel = cyc - start_c;
        if (rel == CPB / 2) check("start_bit", tx, 1'b0);
        for (int k = 1; k <= 8; k++) begin
          if (rel == k * CPB + CPB / 2) mon_byte[k-1] = tx;
        end
        if (rel == 9 * CPB + CPB / 2) check("stop_bit", tx, 1'b1);
        if (rel == FRAME - 1) begin
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            check("frame_without_expectation", 32'd1, 32'd0);
          end else begin
            check("frame_byte", mon_byte, exp_q.pop_front());
            void'(exp_t_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise the send bit for one cycle (optionally with overflow clear), then drop it.
  task automatic push_byte(input logic [7:0] b, input logic clr);
    @(negedge clk);
    io_uart_io_reg  = {$urandom_range(0, 32'h00ff_ffff), 8'h00} | {24'h0, b};
    io_uart_csr_reg = ($urandom() & 32'hffff_fffc) | {30'h0, clr, 1'b1};
    @(negedge clk);
    io_uart_csr_reg = $urandom() & 32'hffff_fffc;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    io_uart_csr_reg = ($urandom() & 32'hffff_fffc) | 32'h2;
    @(negedge clk);
    io_uart_csr_reg = $urandom() & 32'hffff_fffc;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((tx_busy || in_frame || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check({name, "_drain_timeout"}, 32'd1, 32'd0);
    idle_cycles(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    // Reset for 3 cycles, then 100 quiet cycles on an idle line.
    idle_cycles(3);
    check("rst_tx", tx, 1'b1);
    check("rst_fifo_empty", fifo_empty, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    idle_cycles(100);
    check("idle_tx_high", tx, 1'b1);

    // Single byte with the send bit held high: exactly one frame.
    @(negedge clk);
    io_uart_io_reg  = 32'h1234_56A5;
    io_uart_csr_reg = 32'h1;
    idle_cycles(60);
    io_uart_csr_reg = 32'h0;
    wait_idle("single");

    // Two bytes two cycles apart: contiguous frames.
    push_byte(8'h55, 1'b0);
    push_byte(8'h0F, 1'b0);
    wait_idle("b2b");

    // Six bytes while the first frame is active: the sixth is dropped.
    for (int i = 1; i <= 6; i++) push_byte(8'(i), 1'b0);
    idle_cycles(2);
    check("ovf_fifo_full", fifo_full, 1'b1);
    check("ovf_set", overflow, 1'b1);
    wait_idle("ovf");
    check("ovf_sticky", overflow, 1'b1);

    // Clear, then a good push, then a drop that coincides with clear.
    pulse_clear();
    check("ovf_cleared", overflow, 1'b0);
    push_byte(8'hC3, 1'b0);
    wait_idle("after_clear");
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i), 1'b0);
    push_byte(8'hEE, 1'b1);
    idle_cycles(1);
    check("drop_with_clear", overflow, 1'b0);
    wait_idle("drop_clear");

    // Reset during data bit 3 with two bytes still queued.
    t0 = cyc + 1;
    push_byte(8'h9A, 1'b0);
    push_byte(8'h3C, 1'b0);
    push_byte(8'hC5, 1'b0);
    while (cyc < t0 + 2 + CPB + 3 * CPB + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", tx, 1'b1);
    check("midrst_empty", fifo_empty, 1'b1);
    idle_cycles(100);
    check("midrst_quiet", tx_busy, 1'b0);

    // Random traffic with random hold, gaps and occasional overflow clears.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      io_uart_io_reg  = $urandom();
      io_uart_csr_reg = ($urandom() & 32'hffff_fffc) | 32'h1 |
                        (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      io_uart_csr_reg = $urandom() & 32'hffff_fffc;
      repeat ($urandom_range(1, 45)) @(negedge clk);
    end
    wait_idle("random");
    check("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
